// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO drain path.
package fifo_pkg;
    localparam int LAT_FWFT = 0;
    localparam int LAT_STD  = 1;

    typedef logic [1:0] occ_t;
endpackage

// File: rtl/skid_buffer_2.sv
// Two-entry ordered output buffer. The head entry drives the stream port directly,
// so both valid and data come straight from flops.
module skid_buffer_2 import fifo_pkg::*; #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  valid,
    output occ_t                  occ
);
    logic [DATA_WIDTH-1:0] tail;
    logic [DATA_WIDTH-1:0] head_n;
    logic [DATA_WIDTH-1:0] tail_n;
    occ_t                  occ_n;

    // The issuer never pushes into a full buffer without a simultaneous pop.
    always_comb begin
        head_n = head;
        tail_n = tail;
        occ_n  = occ;
        if (flush) begin
            occ_n = '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) head_n = push_data;
                    else             tail_n = push_data;
                    occ_n = occ + 2'd1;
                end
                2'b01: begin
                    head_n = tail;
                    occ_n  = occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        head_n = push_data;
                    end else begin
                        head_n = tail;
                        tail_n = push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            occ   <= '0;
            valid <= 1'b0;
        end else begin
            head  <= head_n;
            tail  <= tail_n;
            occ   <= occ_n;
            valid <= (occ_n != 2'd0);
        end
    end
endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO into a valid/ready stream, hiding FWFT or standard
// read latency behind a 2-entry buffer while sustaining one word per cycle.
module fifo_stream_reader import fifo_pkg::*; #(
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = LAT_STD
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
    input  logic                  fifo_empty_i,
    output logic                  fifo_read_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    input  logic                  flush_i,
    output logic [1:0]            occupancy_o,
    output logic [31:0]           xfer_count_o
);
    generate
        if (READ_LATENCY != LAT_FWFT && READ_LATENCY != LAT_STD) begin : g_bad_latency
            $error("fifo_stream_reader: READ_LATENCY must be 0 (FWFT) or 1 (standard)");
        end
    endgenerate

    occ_t        occ;
    logic        inflight;
    logic        drop;
    logic        pop;
    logic        push;
    logic [2:0]  credit;
    logic [31:0] xfer_cnt;

    assign pop    = m_valid_o & m_ready_i;
    assign credit = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

    // Counting this cycle's pop as freed space is what lets a full buffer keep streaming.
    assign fifo_read_o = !fifo_empty_i && !flush_i && !rst_i && (credit < 3'd2);

    assign push = (READ_LATENCY == LAT_STD) ? (inflight & ~drop) : fifo_read_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight <= 1'b0;
            drop     <= 1'b0;
            xfer_cnt <= '0;
        end else begin
            inflight <= (READ_LATENCY == LAT_STD) && fifo_read_o;
            drop     <= flush_i;
            if (pop) xfer_cnt <= xfer_cnt + 32'd1;
        end
    end

    skid_buffer_2 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_buf (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (push),
        .push_data (fifo_rd_data_i),
        .pop       (pop),
        .flush     (flush_i),
        .head      (m_data_o),
        .valid     (m_valid_o),
        .occ       (occ)
    );

    assign occupancy_o  = occ;
    assign xfer_count_o = xfer_cnt;
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Runs an FWFT lane and a standard-FIFO lane side by side against a queue-based
// model of the upstream FIFO and of the expected stream contents.
module tb_fifo_stream_reader;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic flush;
    logic ready;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input int lane, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL lane%0d %s: got 0x%08h expected 0x%08h (cycle %0d)", lane, nm, act, exp, cyc);
        end
    endtask

    task automatic chk_seq(input int lane, input string nm, input logic [31:0] q[$],
                           input logic [31:0] first, input int n);
        chk(lane, {nm, "_count"}, q.size(), n);
        for (int i = 0; i < q.size() && i < n; i++) chk(lane, nm, q[i], first + i);
    endtask

    for (genvar g = 0; g < 2; g++) begin : ln
        localparam int LAT = g;

        logic [DW-1:0] rd_data = '0;
        logic [DW-1:0] nxt_rd = '0;
        logic          empty = 1'b1;
        logic          nxt_empty = 1'b1;
        logic [DW-1:0] data;
        logic          read;
        logic          valid;
        logic [1:0]    occ;
        logic [31:0]   xfer;

        logic [DW-1:0] fq[$];
        logic [DW-1:0] mb[$];
        logic [DW-1:0] got[$];
        int            got_cyc[$];
        logic [DW-1:0] pend = '0;
        bit            pend_v = 1'b0;
        bit            last_rst = 1'b1;
        logic [31:0]   m_cnt = '0;
        int            n_reads = 0;
        int            n_rd_empty = 0;
        int            first_read = -1;
        int            first_valid = -1;

        fifo_stream_reader #(
            .DATA_WIDTH(DW),
            .READ_LATENCY(LAT)
        ) dut (
            .clk_i          (clk),
            .rst_i          (rst),
            .fifo_rd_data_i (rd_data),
            .fifo_empty_i   (empty),
            .fifo_read_o    (read),
            .m_data_o       (data),
            .m_valid_o      (valid),
            .m_ready_i      (ready),
            .flush_i        (flush),
            .occupancy_o    (occ),
            .xfer_count_o   (xfer)
        );

        always @(posedge clk) begin
            empty   <= nxt_empty;
            rd_data <= nxt_rd;
        end

        initial forever begin
            @(negedge clk);
            begin : step
                logic [DW-1:0] w;
                logic [DW-1:0] arr;
                bit            ev;
                bit            pop;
                bit            arr_v;
                bit            popped;
                int            credit;

                ev     = (mb.size() != 0);
                pop    = ev && ready;
                credit = mb.size() + int'(pend_v) - int'(pop);
                chk(g, "fifo_read", read, (!empty && !flush && !rst && credit < 2));
                chk(g, "m_valid", valid, ev);
                chk(g, "occupancy", occ, mb.size());
                chk(g, "xfer_count", xfer, m_cnt);
                if (ev) chk(g, "m_data", data, mb[0]);
                if (last_rst) chk(g, "m_data_reset", data, 0);

                if (read) n_reads++;
                if (read && empty) n_rd_empty++;
                if (read && first_read < 0) first_read = cyc;
                if (valid && first_valid < 0) first_valid = cyc;

                popped = 1'b0;
                w      = '0;
                if (read && fq.size() > 0) begin
                    w      = fq.pop_front();
                    popped = 1'b1;
                end
                if (LAT == 0) begin
                    arr_v = popped;
                    arr   = w;
                end else begin
                    arr_v = pend_v;
                    arr   = pend;
                end
                pend_v = 1'b0;

                if (rst) begin
                    mb.delete();
                    m_cnt = '0;
                end else begin
                    if (pop) begin
                        got.push_back(mb[0]);
                        got_cyc.push_back(cyc);
                        void'(mb.pop_front());
                        m_cnt++;
                    end
                    if (flush) mb.delete();
                    else if (arr_v && mb.size() < 2) mb.push_back(arr);
                    if (LAT == 1 && popped && !flush) begin
                        pend   = w;
                        pend_v = 1'b1;
                    end
                end
                last_rst = rst;

                nxt_empty = (fq.size() == 0);
                if (LAT == 0) begin
                    if (fq.size() > 0) nxt_rd = fq[0];
                end else if (popped) begin
                    nxt_rd = w;
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fill(input logic [31:0] w);
        ln[0].fq.push_back(w);
        ln[1].fq.push_back(w);
    endtask

    task automatic clear_stats();
        ln[0].got.delete();     ln[1].got.delete();
        ln[0].got_cyc.delete(); ln[1].got_cyc.delete();
        ln[0].n_reads = 0;      ln[1].n_reads = 0;
        ln[0].n_rd_empty = 0;   ln[1].n_rd_empty = 0;
        ln[0].first_read = -1;  ln[1].first_read = -1;
        ln[0].first_valid = -1; ln[1].first_valid = -1;
    endtask

    initial begin
        int n;
        rst   = 1'b1;
        flush = 1'b0;
        ready = 1'b0;
        tick(3);
        chk(0, "reset_valid", ln[0].valid, 0);
        chk(1, "reset_valid", ln[1].valid, 0);
        chk(0, "reset_xfer", ln[0].xfer, 0);
        chk(1, "reset_read", ln[1].read, 0);
        rst = 1'b0;

        // Continuous drain of 8 words.
        clear_stats();
        ready = 1'b1;
        for (int i = 0; i < 8; i++) fill(32'h11 + i);
        tick(14);
        chk_seq(0, "burst", ln[0].got, 32'h11, 8);
        chk_seq(1, "burst", ln[1].got, 32'h11, 8);
        chk(0, "burst_xfer", ln[0].xfer, 8);
        chk(1, "burst_xfer", ln[1].xfer, 8);
        chk(0, "first_word_latency", ln[0].first_valid - ln[0].first_read, 1);
        chk(1, "first_word_latency", ln[1].first_valid - ln[1].first_read, 2);
        chk(0, "burst_span", (ln[0].got_cyc.size() == 8) ? ln[0].got_cyc[7] - ln[0].got_cyc[0] : -1, 7);
        chk(1, "burst_span", (ln[1].got_cyc.size() == 8) ? ln[1].got_cyc[7] - ln[1].got_cyc[0] : -1, 7);

        // Backpressure with 5 words waiting.
        clear_stats();
        ready = 1'b0;
        for (int i = 0; i < 5; i++) fill(32'h21 + i);
        tick(10);
        chk(0, "bp_reads", ln[0].n_reads, 2);
        chk(1, "bp_reads", ln[1].n_reads, 2);
        chk(0, "bp_occ", ln[0].occ, 2);
        chk(1, "bp_occ", ln[1].occ, 2);
        chk(0, "bp_data", ln[0].data, 32'h21);
        chk(1, "bp_data", ln[1].data, 32'h21);
        ready = 1'b1;
        tick(10);
        chk_seq(0, "bp_release", ln[0].got, 32'h21, 5);
        chk_seq(1, "bp_release", ln[1].got, 32'h21, 5);

        // Single word with toggling ready.
        clear_stats();
        ready = 1'b0;
        fill(32'h31);
        for (int i = 0; i < 12; i++) begin
            ready = (i % 2 == 0);
            tick();
        end
        ready = 1'b1;
        tick(3);
        chk(0, "single_reads", ln[0].n_reads, 1);
        chk(1, "single_reads", ln[1].n_reads, 1);
        chk(0, "read_while_empty", ln[0].n_rd_empty, 0);
        chk(1, "read_while_empty", ln[1].n_rd_empty, 0);
        chk_seq(0, "single", ln[0].got, 32'h31, 1);
        chk_seq(1, "single", ln[1].got, 32'h31, 1);

        // Flush the cycle after a read issue; standard lane has one word buffered, one in flight.
        clear_stats();
        ready = 1'b0;
        fill(32'h41);
        fill(32'h42);
        tick(3);
        chk(1, "pre_flush_occ", ln[1].occ, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk(0, "flush_occ", ln[0].occ, 0);
        chk(1, "flush_occ", ln[1].occ, 0);
        chk(1, "flush_valid", ln[1].valid, 0);
        chk(1, "flush_reads", ln[1].n_reads, 2);
        tick();
        chk(1, "flush_drop_valid", ln[1].valid, 0);
        clear_stats();
        fill(32'h43);
        fill(32'h44);
        ready = 1'b1;
        tick(8);
        chk_seq(0, "post_flush", ln[0].got, 32'h43, 2);
        chk_seq(1, "post_flush", ln[1].got, 32'h43, 2);

        // Reset mid-burst: words read before reset never reappear.
        ready = 1'b1;
        for (int i = 0; i < 8; i++) fill(32'h51 + i);
        tick(4);
        rst = 1'b1;
        tick();
        chk(0, "midrst_valid", ln[0].valid, 0);
        chk(1, "midrst_valid", ln[1].valid, 0);
        chk(0, "midrst_data", ln[0].data, 0);
        chk(1, "midrst_data", ln[1].data, 0);
        chk(0, "midrst_occ", ln[0].occ, 0);
        chk(1, "midrst_xfer", ln[1].xfer, 0);
        rst = 1'b0;
        clear_stats();
        tick(12);
        chk_seq(0, "after_reset", ln[0].got, 32'h54, 5);
        chk_seq(1, "after_reset", ln[1].got, 32'h54, 5);

        // Counter wrap from a preloaded all-ones value.
        force ln[0].dut.xfer_cnt = 32'hFFFF_FFFF;
        force ln[1].dut.xfer_cnt = 32'hFFFF_FFFF;
        ln[0].m_cnt = 32'hFFFF_FFFF;
        ln[1].m_cnt = 32'hFFFF_FFFF;
        tick();
        release ln[0].dut.xfer_cnt;
        release ln[1].dut.xfer_cnt;
        tick();
        chk(0, "preload", ln[0].xfer, 32'hFFFF_FFFF);
        chk(1, "preload", ln[1].xfer, 32'hFFFF_FFFF);
        clear_stats();
        fill(32'h61);
        tick(5);
        chk(0, "wrap", ln[0].xfer, 32'h0);
        chk(1, "wrap", ln[1].xfer, 32'h0);
        chk_seq(0, "wrap_word", ln[0].got, 32'h61, 1);

        // Randomized traffic with occasional flush and reset; checked every cycle by the model.
        for (int c = 0; c < 800; c++) begin
            ready = ($urandom_range(3) != 0);
            flush = ($urandom_range(39) == 0);
            rst   = ($urandom_range(199) == 0);
            if (ln[0].fq.size() < 12 && ln[1].fq.size() < 12) begin
                n = $urandom_range(2);
                repeat (n) fill($urandom);
            end
            tick();
        end
        rst   = 1'b0;
        flush = 1'b0;
        ready = 1'b1;
        tick(40);
        chk(0, "drained_valid", ln[0].valid, 0);
        chk(1, "drained_valid", ln[1].valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
